// File: rtl/debounce8.sv
// Eight-channel push-button / switch conditioner.
// Each raw input passes a two-flop synchroniser, then a per-channel stability
// counter that only lets the registered level follow the synchronised input
// after DEBOUNCE_CYCLES consecutive differing samples. One-cycle rise/fall
// strobes accompany every level change.
module debounce8 #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  output logic [7:0] out,
  output logic [7:0] rise,
  output logic [7:0] fall
);

  // Terminal count: the change is accepted on the DEBOUNCE_CYCLES-th
  // consecutive mismatching sample.
  localparam logic [CNT_WIDTH-1:0] TermCnt = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

  logic [7:0]           sync1_q, sync2_q;
  logic [7:0]           out_q, out_d;
  logic [7:0]           rise_q, rise_d;
  logic [7:0]           fall_q, fall_d;
  logic [CNT_WIDTH-1:0] cnt_q [8];
  logic [CNT_WIDTH-1:0] cnt_d [8];

  // Per-channel filter next state; terminal compare precedes the increment,
  // so a counter can never wrap.
  always_comb begin
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != out_q[i]) begin
        if (cnt_q[i] == TermCnt) begin
          out_d[i]  = sync2_q[i];
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end
    end
  end

  // Synchroniser, filter state and strobes; reset dominates everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      out_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_debounce8.sv
// Bench for debounce8 with DEBOUNCE_CYCLES=4, CNT_WIDTH=3.
// Stimulus pushes the expected post-edge response of a reference model into a
// queue; a monitor pops and compares it shortly after every rising edge.
// Directed scenarios additionally check hand-computed constants.
module tb_debounce8;

  localparam int unsigned D = 4;

  typedef struct packed {
    logic [7:0] lvl;
    logic [7:0] rs;
    logic [7:0] fl;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] in_v;
  logic [7:0] dut_out, dut_rise, dut_fall;

  int n_checks   = 0;
  int n_failures = 0;

  exp_t sb_q[$];

  // Reference model state
  logic [7:0] m_s1, m_s2, m_out;
  int         m_run [8];

  debounce8 #(
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH      (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .in   (in_v),
    .out  (dut_out),
    .rise (dut_rise),
    .fall (dut_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one edge's worth of inputs, predict the response, advance a cycle.
  task automatic step(input logic [7:0] v, input logic r);
    exp_t e;
    in_v  = v;
    reset = r;
    e.rs  = '0;
    e.fl  = '0;
    if (r) begin
      m_s1  = '0;
      m_s2  = '0;
      m_out = '0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (m_s2[i] !== m_out[i]) begin
          m_run[i]++;
          if (m_run[i] == int'(D)) begin
            m_out[i] = m_s2[i];
            e.rs[i]  = m_s2[i];
            e.fl[i]  = ~m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = v;
    end
    e.lvl = m_out;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: the DUT presents a response every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_out", dut_out, e.lvl);
        chk("sb_rise", dut_rise, e.rs);
        chk("sb_fall", dut_fall, e.fl);
        chk("sb_any", {7'd0, |dut_out}, {7'd0, |e.lvl});
        chk("sb_excl", dut_rise & dut_fall, 8'h00);
      end
    end
  end

  initial begin
    int rise5_cnt;
    int rise5_at;
    int n;
    logic [7:0] v;
    logic r;

    in_v  = 8'h00;
    reset = 1'b1;

    // Inputs held high through reset
    for (int k = 0; k < 3; k++) step(8'hFF, 1'b1);
    chk("rst_out", dut_out, 8'h00);
    chk("rst_rise", dut_rise, 8'h00);
    chk("rst_fall", dut_fall, 8'h00);
    for (int k = 1; k <= 7; k++) begin
      step(8'hFF, 1'b0);
      if (k <= 5) begin
        chk("t1_out_hold", dut_out, 8'h00);
        chk("t1_rise_hold", dut_rise, 8'h00);
      end else if (k == 6) begin
        chk("t1_out", dut_out, 8'hFF);
        chk("t1_rise", dut_rise, 8'hFF);
        chk("t1_any", {7'd0, |dut_out}, 8'h01);
      end else begin
        chk("t1_rise_clr", dut_rise, 8'h00);
        chk("t1_out_keep", dut_out, 8'hFF);
      end
    end

    // Release all, then single-channel press
    for (int k = 1; k <= 9; k++) begin
      step(8'h00, 1'b0);
      if (k == 6) chk("t2_fall_all", dut_fall, 8'hFF);
    end
    chk("t2_idle", dut_out, 8'h00);
    for (int k = 1; k <= 7; k++) begin
      step(8'h01, 1'b0);
      if (k <= 5) chk("t2_out_hold", dut_out, 8'h00);
      else if (k == 6) begin
        chk("t2_out", dut_out, 8'h01);
        chk("t2_rise", dut_rise, 8'h01);
      end else chk("t2_rise_clr", dut_rise, 8'h00);
      chk("t2_fall", dut_fall, 8'h00);
    end
    for (int k = 0; k < 8; k++) step(8'h00, 1'b0);

    // Short pulse on channel 3 is rejected
    for (int k = 0; k < 3; k++) step(8'h08, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(8'h00, 1'b0);
      chk("t3_out", dut_out, 8'h00);
      chk("t3_strobe", dut_rise | dut_fall, 8'h00);
    end

    // Chatter on channel 5, then stable high
    step(8'h20, 1'b0);
    step(8'h00, 1'b0);
    step(8'h20, 1'b0);
    step(8'h20, 1'b0);
    step(8'h00, 1'b0);
    rise5_cnt = 0;
    rise5_at  = 0;
    for (int k = 1; k <= 10; k++) begin
      step(8'h20, 1'b0);
      if (dut_rise[5]) begin
        rise5_cnt++;
        if (rise5_at == 0) rise5_at = k;
      end
    end
    chk("t4_rise_cnt", 8'(rise5_cnt), 8'd1);
    chk("t4_rise_at", 8'(rise5_at), 8'd6);
    chk("t4_out", dut_out, 8'h20);
    for (int k = 0; k < 8; k++) step(8'h00, 1'b0);

    // Staggered multi-channel press and common release
    for (int k = 1; k <= 10; k++) begin
      step((k <= 2) ? 8'hA5 : 8'hFF, 1'b0);
      if (k == 6) chk("t5_rise_a5", dut_rise, 8'hA5);
      else if (k == 8) chk("t5_rise_5a", dut_rise, 8'h5A);
      else chk("t5_rise_idle", dut_rise, 8'h00);
    end
    for (int k = 1; k <= 8; k++) begin
      step(8'h00, 1'b0);
      if (k == 6) chk("t5_fall", dut_fall, 8'hFF);
      else chk("t5_fall_idle", dut_fall, 8'h00);
    end

    // Reset mid-count discards progress
    for (int k = 0; k < 4; k++) step(8'h01, 1'b0);
    step(8'h01, 1'b1);
    chk("t6_rst_out", dut_out, 8'h00);
    chk("t6_rst_rise", dut_rise, 8'h00);
    for (int k = 1; k <= 7; k++) begin
      step(8'h01, 1'b0);
      if (k <= 5) begin
        chk("t6_out_hold", dut_out, 8'h00);
        chk("t6_rise_hold", dut_rise, 8'h00);
      end else if (k == 6) begin
        chk("t6_out", dut_out, 8'h01);
        chk("t6_rise", dut_rise, 8'h01);
      end
    end
    for (int k = 0; k < 8; k++) step(8'h00, 1'b0);

    // Random vectors with random hold times and rare resets
    for (int t = 0; t < 10000; t++) begin
      v = 8'($urandom);
      n = $urandom_range(1, 10);
      r = ($urandom_range(0, 499) == 0);
      for (int j = 0; j < n; j++) step(v, r && (j == 0));
    end
    for (int k = 0; k < 3; k++) step(8'h00, 1'b0);

    #2;
    chk("sb_drain", 8'(sb_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
